// File: rtl/gain_ramp_if.sv
// Avalon-MM write/readback bus between the gain ramp master and the gain block's
// coefficient slave.
interface gain_ramp_if;
  logic        wr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output wr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  wr,
    input  wr_data,
    output rd_data
  );
endinterface

// File: rtl/gain_ramp.sv
// Gain coefficient ramp: walks the gain block's coefficient to a commanded target
// in bounded steps, one Avalon write every DIV sample strobes.
module gain_ramp #(
  parameter int COEF_WDT = 16,
  parameter int STEP_WDT = 16,
  parameter int DIV_WDT  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_st,
  input  logic [COEF_WDT-1:0] i_cmd_target,
  input  logic [STEP_WDT-1:0] i_cmd_step,
  input  logic [DIV_WDT-1:0]  i_cmd_div,
  input  logic                i_sample_st,
  gain_ramp_if.master         avm,
  output logic                o_busy,
  output logic                o_done
);

  if ((COEF_WDT % 2) != 0 || COEF_WDT > 32 || COEF_WDT < 2 || STEP_WDT > COEF_WDT) begin : g_param_check
    $error("gain_ramp: COEF_WDT must be even and <= 32, STEP_WDT <= COEF_WDT");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COEF_WDT-1:0] r_target;
  logic [STEP_WDT-1:0] r_step;
  logic [DIV_WDT-1:0]  r_div;
  logic [COEF_WDT-1:0] r_cur;
  logic [DIV_WDT-1:0]  r_cnt;
  logic                r_avm_wr;
  logic [COEF_WDT-1:0] r_avm_wr_data;
  logic                r_busy;
  logic                r_done;

  logic [DIV_WDT-1:0]  w_div_eff;
  logic [DIV_WDT:0]    w_cnt_inc;
  logic                w_div_hit;
  logic [COEF_WDT:0]   w_cur_x;
  logic [COEF_WDT:0]   w_tgt_x;
  logic [COEF_WDT:0]   w_step_x;
  logic [COEF_WDT:0]   w_sum;
  logic [COEF_WDT:0]   w_diff;
  logic [COEF_WDT-1:0] w_next;
  logic [COEF_WDT-1:0] w_rd_coef;
  logic                w_unused_rd;

  assign w_rd_coef   = avm.rd_data[COEF_WDT-1:0];
  assign w_unused_rd = ^avm.rd_data;

  // A divider of zero behaves as one: every sample strobe triggers an update.
  assign w_div_eff = (r_div == {DIV_WDT{1'b0}}) ? DIV_WDT'(1) : r_div;
  assign w_cnt_inc = {1'b0, r_cnt} + (DIV_WDT + 1)'(1);
  assign w_div_hit = (w_cnt_inc >= {1'b0, w_div_eff});

  // One extra bit keeps cur+step and cur-target from wrapping at the rails.
  assign w_cur_x  = {1'b0, r_cur};
  assign w_tgt_x  = {1'b0, r_target};
  assign w_step_x = (COEF_WDT + 1)'(r_step);
  assign w_sum    = w_cur_x + w_step_x;
  assign w_diff   = w_cur_x - w_tgt_x;

  always_comb begin
    w_next = r_target;
    if (r_step == {STEP_WDT{1'b0}}) begin
      w_next = r_target;
    end else if (r_cur < r_target) begin
      w_next = (w_sum >= w_tgt_x) ? r_target : w_sum[COEF_WDT-1:0];
    end else if (r_cur > r_target) begin
      w_next = (w_diff <= w_step_x) ? r_target : (r_cur - COEF_WDT'(r_step));
    end else begin
      w_next = r_target;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_st) w_state_nxt = S_LOAD;
        else          w_state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (w_rd_coef == r_target) w_state_nxt = S_DONE;
        else                       w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_sample_st && w_div_hit) w_state_nxt = S_WRITE;
        else                          w_state_nxt = S_WAIT;
      end
      S_WRITE: begin
        if (w_next == r_target) w_state_nxt = S_DONE;
        else                    w_state_nxt = S_WAIT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_target      <= {COEF_WDT{1'b0}};
      r_step        <= {STEP_WDT{1'b0}};
      r_div         <= {DIV_WDT{1'b0}};
      r_cur         <= {COEF_WDT{1'b0}};
      r_cnt         <= {DIV_WDT{1'b0}};
      r_avm_wr      <= 1'b0;
      r_avm_wr_data <= {COEF_WDT{1'b0}};
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_avm_wr <= (w_state_nxt == S_WRITE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_WRITE) begin
        r_avm_wr_data <= w_next;
      end else begin
        r_avm_wr_data <= r_avm_wr_data;
      end
      case (r_state)
        S_IDLE: begin
          if (i_cmd_st) begin
            r_target <= i_cmd_target;
            r_step   <= i_cmd_step;
            r_div    <= i_cmd_div;
          end else begin
            r_target <= r_target;
          end
        end
        S_LOAD: begin
          r_cur <= w_rd_coef;
          r_cnt <= {DIV_WDT{1'b0}};
        end
        S_WAIT: begin
          if (i_sample_st) r_cnt <= w_cnt_inc[DIV_WDT-1:0];
          else             r_cnt <= r_cnt;
        end
        S_WRITE: begin
          r_cur <= w_next;
          r_cnt <= {DIV_WDT{1'b0}};
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign avm.wr      = r_avm_wr;
  assign avm.wr_data = 32'(r_avm_wr_data);
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
